// File: rtl/uart_sram_loader_pkg.sv
// Shared definitions for the UART-to-SRAM loader: state encoding, the header
// delimiter byte and a byte-lane helper.
`timescale 1ns/1ps
package uart_sram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_WAIT,
        HDR_ACK,
        BYTE_WAIT,
        BYTE_ACK,
        WRITE,
        DONE
    } uart_sram_loader_state_type;

    localparam logic [7:0] LF = 8'h0A;

    // Lane that receives the byte at position idx within a word.
    function automatic int unsigned byte_lane(input int unsigned idx,
                                              input int unsigned bytes_per_word,
                                              input logic        big_endian);
        return big_endian ? (bytes_per_word - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/uart_sram_loader_if.sv
// Receiver unload handshake and SRAM write port of the loader, bundled so the
// top level wires one connection per side.
`timescale 1ns/1ps
interface uart_sram_loader_if #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [7:0]            Rx_data;
    logic                  Rx_empty;
    logic                  Rx_enable;
    logic                  Rx_unload;
    logic [ADDR_WIDTH-1:0] SRAM_address;
    logic [DATA_WIDTH-1:0] SRAM_write_data;
    logic                  SRAM_we_n;

    modport master (
        input  Rx_data,
        input  Rx_empty,
        output Rx_enable,
        output Rx_unload,
        output SRAM_address,
        output SRAM_write_data,
        output SRAM_we_n
    );

    modport slave (
        output Rx_data,
        output Rx_empty,
        input  Rx_enable,
        input  Rx_unload,
        input  SRAM_address,
        input  SRAM_write_data,
        input  SRAM_we_n
    );

endinterface

// File: rtl/uart_sram_loader.sv
// Streams UART bytes into SRAM words: optional LF-delimited header strip,
// selectable byte order, count- or address-limited completion.
`timescale 1ns/1ps
module uart_sram_loader
    import uart_sram_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH    = 18,
    parameter int unsigned           DATA_WIDTH    = 16,
    parameter int unsigned           HEADER_LF_MAX = 3,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX      = '1
) (
    input  logic                                   Clock,
    input  logic                                   Reset,
    input  logic                                   Initialize,
    input  logic                                   Enable,
    input  logic [ADDR_WIDTH-1:0]                  Start_address,
    input  logic [ADDR_WIDTH-1:0]                  Num_words,
    input  logic [$clog2(HEADER_LF_MAX+1)-1:0]     Header_lf,
    input  logic                                   Big_endian,
    uart_sram_loader_if.master                     bus,
    output logic [ADDR_WIDTH-1:0]                  Words_written,
    output logic                                   Busy,
    output logic                                   Done,
    output logic                                   Overflow
);

    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int unsigned IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned HDR_W          = $clog2(HEADER_LF_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);

    uart_sram_loader_state_type state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_n_q,  we_n_d;
    logic                  rx_en_q, rx_en_d;
    logic                  unload_q, unload_d;
    logic [ADDR_WIDTH-1:0] words_q, words_d;
    logic                  ovf_q,   ovf_d;
    logic [ADDR_WIDTH-1:0] num_q,   num_d;
    logic [HDR_W-1:0]      hdr_q,   hdr_d;
    logic [HDR_W-1:0]      lf_q,    lf_d;
    logic                  big_q,   big_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;

    always_ff @(posedge Clock) begin
        if (Reset || Initialize) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_n_q   <= 1'b1;
            rx_en_q  <= 1'b0;
            unload_q <= 1'b0;
            words_q  <= '0;
            ovf_q    <= 1'b0;
            num_q    <= '0;
            hdr_q    <= '0;
            lf_q     <= '0;
            big_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_n_q   <= we_n_d;
            rx_en_q  <= rx_en_d;
            unload_q <= unload_d;
            words_q  <= words_d;
            ovf_q    <= ovf_d;
            num_q    <= num_d;
            hdr_q    <= hdr_d;
            lf_q     <= lf_d;
            big_q    <= big_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_n_d   = we_n_q;
        rx_en_d  = rx_en_q;
        unload_d = unload_q;
        words_d  = words_q;
        ovf_d    = ovf_q;
        num_d    = num_q;
        hdr_d    = hdr_q;
        lf_d     = lf_q;
        big_d    = big_q;
        idx_d    = idx_q;

        case (state_q)
            IDLE: begin
                if (Enable) begin
                    addr_d  = Start_address;
                    num_d   = Num_words;
                    hdr_d   = Header_lf;
                    big_d   = Big_endian;
                    idx_d   = '0;
                    lf_d    = '0;
                    words_d = '0;
                    ovf_d   = 1'b0;
                    rx_en_d = 1'b1;
                    state_d = (Header_lf != '0) ? HDR_WAIT : BYTE_WAIT;
                end
            end

            HDR_WAIT: begin
                if (!bus.Rx_empty) begin
                    unload_d = 1'b1;
                    if (bus.Rx_data == LF)
                        lf_d = lf_q + HDR_W'(1);
                    state_d = HDR_ACK;
                end
            end

            HDR_ACK: begin
                if (bus.Rx_empty) begin
                    unload_d = 1'b0;
                    state_d  = (lf_q == hdr_q) ? BYTE_WAIT : HDR_WAIT;
                end
            end

            BYTE_WAIT: begin
                if (!bus.Rx_empty) begin
                    unload_d = 1'b1;
                    // Lanes not addressed by this byte keep the previous word's bytes.
                    for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
                        if (byte_lane(int'(idx_q), BYTES_PER_WORD, big_q) == b)
                            wdata_d[8*b +: 8] = bus.Rx_data;
                    end
                    state_d = BYTE_ACK;
                end
            end

            BYTE_ACK: begin
                if (bus.Rx_empty) begin
                    unload_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        we_n_d  = 1'b0;
                        state_d = WRITE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = BYTE_WAIT;
                    end
                end
            end

            WRITE: begin
                we_n_d  = 1'b1;
                words_d = words_q + ADDR_WIDTH'(1);
                if ((num_q != '0) && (words_d == num_q)) begin
                    rx_en_d = 1'b0;
                    state_d = DONE;
                end else if (addr_q == ADDR_MAX) begin
                    ovf_d   = (num_q != '0);
                    rx_en_d = 1'b0;
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = BYTE_WAIT;
                end
            end

            DONE: begin
                rx_en_d = 1'b0;
                if (!Enable)
                    state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.SRAM_address    = addr_q;
    assign bus.SRAM_write_data = wdata_q;
    // Strobe is registered; Initialize also masks it so an abort landing on WRITE writes nothing.
    assign bus.SRAM_we_n       = we_n_q | Initialize;
    assign bus.Rx_enable       = rx_en_q;
    assign bus.Rx_unload       = unload_q;
    assign Words_written       = words_q;
    assign Overflow            = ovf_q;
    assign Done                = (state_q == DONE);
    assign Busy                = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: doc/uart_sram_loader.md
Name: uart_sram_loader

Overview:
Parametrised successor to the UART-to-SRAM upload path. It consumes bytes from the existing UART receive controller's unload handshake and can optionally strip a text header of N line feeds. Bytes are packed into DATA_WIDTH-bit words in a selectable byte order and written to SRAM from a runtime start address. Completion comes from a word count or from the top-address limit, with a status counter and a Done flag. It sits between UART_receive_controller and the SRAM mux in the top level, replacing the fixed 16-bit, fixed-base loader.

Parameters:
ADDR_WIDTH, 18, SRAM address width
DATA_WIDTH, 16, SRAM word width; must be a multiple of 8, range 8..64
HEADER_LF_MAX, 3, width-sizing bound for the Header_lf input; Header_lf must be ≤ this value
ADDR_MAX, 2**ADDR_WIDTH-1, highest writable address; the loader never writes above it

Ports:
Clock  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
Initialize  in  1  synchronous abort and return to IDLE, same effect as Reset except Done/Overflow (see below)
Enable  in  1  level; sampled in IDLE to start a transfer
Start_address  in  ADDR_WIDTH  first word address, latched on start
Num_words  in  ADDR_WIDTH  words to write, latched on start; 0 means until ADDR_MAX
Header_lf  in  $clog2(HEADER_LF_MAX+1)  count of 8'h0A bytes to discard before payload, latched on start
Big_endian  in  1  1: first byte goes to MSB; 0: first byte goes to LSB; latched on start
Rx_data  in  8  byte from the UART receiver
Rx_empty  in  1  receiver empty flag
Rx_enable  out  1  receiver enable
Rx_unload  out  1  receiver unload request
SRAM_address  out  ADDR_WIDTH  write address
SRAM_write_data  out  DATA_WIDTH  write data
SRAM_we_n  out  1  active-low write strobe
Words_written  out  ADDR_WIDTH  count of completed writes this transfer
Busy  out  1  high in any state other than IDLE or DONE
Done  out  1  high in DONE; stays high until Enable drops
Overflow  out  1  sticky; set when ADDR_MAX is reached before Num_words is satisfied

Behaviour:
- Reset values: SRAM_we_n=1; SRAM_address=0; SRAM_write_data=0; Rx_enable=0; Rx_unload=0; Words_written=0; Busy=0; Done=0; Overflow=0; state=IDLE.
- Initialize has Reset's effect on all state except Done/Overflow, which are also cleared. Initialize has priority over every state. A partial word is discarded, and no write is issued in the cycle Initialize is high.
- IDLE: on Enable=1 && Done=0:
  - latch Start_address into SRAM_address and latch Num_words, Header_lf and Big_endian;
  - clear the byte index, Words_written and Overflow; set Rx_enable=1;
  - go to HDR_WAIT if the latched header count is >0, else BYTE_WAIT.
- HDR_WAIT: when Rx_empty=0, set Rx_unload=1; if Rx_data==8'h0A, increment lf_count; go to HDR_ACK.
- HDR_ACK: when Rx_empty=1, set Rx_unload=0; go to BYTE_WAIT if lf_count==header count, else HDR_WAIT.
- BYTE_WAIT: when Rx_empty=0, set Rx_unload=1 and place Rx_data in byte lane k, then go to BYTE_ACK.
  - k = BYTES_PER_WORD-1-idx if Big_endian, else idx, where BYTES_PER_WORD = DATA_WIDTH/8.
  - Unwritten lanes hold the previous word's values.
- BYTE_ACK: when Rx_empty=1, set Rx_unload=0. If idx==BYTES_PER_WORD-1, set idx=0 and go to WRITE; else idx+1 and go to BYTE_WAIT.
- WRITE: exactly one cycle with SRAM_we_n=0; address and data are already stable from the previous cycle and held through this cycle. Next cycle: SRAM_we_n=1 and Words_written+1, then:
  - if the new Words_written equals a nonzero Num_words, go to DONE;
  - else if SRAM_address==ADDR_MAX, set Overflow only when Num_words≠0, then go to DONE;
  - else increment SRAM_address and go to BYTE_WAIT.
- DONE: Rx_enable=0, Done=1, SRAM_address holds the last written address. When Enable=0, clear Done and go to IDLE.
- Latency: last byte unload acknowledged (Rx_empty returns 1) → WRITE state next cycle → we_n low for 1 cycle.
- The write address never wraps past ADDR_MAX. Num_words > ADDR_MAX-Start_address+1 results in Overflow=1 and Done=1.
- Changes to Start_address/Num_words/Header_lf/Big_endian while Busy are ignored.
- The state holds indefinitely while Rx_empty does not change; there is no timeout.

Decomposition:
- The state enum uart_sram_loader_state_type (IDLE, HDR_WAIT, HDR_ACK, BYTE_WAIT, BYTE_ACK, WRITE, DONE) is added to the shared state-definition header alongside the existing state types.
- The LF constant 8'h0A goes in the shared package.
- No sub-module: the byte handshake and the lane mux are small enough to stay in one process.
- The top level instantiates UART_receive_controller separately and wires it to this block.

Test Plan:
1. Header strip: DATA_WIDTH=16, Header_lf=3, Big_endian=1, Start_address=18'h6C00, Num_words=2. Stream "P6\n4 2\n255\n" then 8'h12, 8'h34, 8'hAB, 8'hCD → writes 16'h1234@6C00 and 16'hABCD@6C01, each with one we_n-low cycle; Words_written=2; Done=1.
2. Little-endian 32-bit: DATA_WIDTH=32, Big_endian=0, Header_lf=0, Num_words=1; bytes 01 02 03 04 → one write of 32'h04030201 at Start_address.
3. Top limit: Start_address=ADDR_MAX-1, Num_words=5, 16-bit → 2 writes, at ADDR_MAX-1 and ADDR_MAX; Overflow=1, Done=1, no write above ADDR_MAX.
4. Num_words=0 from ADDR_MAX-2 → 3 writes, then Done=1 with Overflow=0.
5. Initialize mid-word, after 1 of 2 bytes → no write, IDLE next cycle, Rx_enable=0. Restart writes fresh words with no stale lane data at Start_address.
6. Reset held during WRITE → SRAM_we_n=1 on the next edge and all outputs at their reset values; Enable held high after DONE gives no second transfer until Enable drops.
